// File: rtl/nx_fifo_pkg.sv
// Shared helpers for the nx_fifo_flex family: width calculations and the decoded flag bundle.
package nx_fifo_pkg;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int unsigned fifo_cw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned fifo_pw(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_flags_t;

endpackage

// File: rtl/nx_fifo_ctrl_flex.sv
// Control path of nx_fifo_flex: wrapping pointers, occupancy, threshold flags,
// high-watermark and registered underflow/overflow pulses.
module nx_fifo_ctrl_flex
    import nx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH            = 4,
    parameter int unsigned AFULL_THRESH     = DEPTH - 1,
    parameter int unsigned AEMPTY_THRESH    = 1,
    parameter bit          UNDERFLOW_ASSERT = 1'b1,
    parameter bit          OVERFLOW_ASSERT  = 1'b1,
    localparam int unsigned CW              = fifo_cw(DEPTH),
    localparam int unsigned PW              = fifo_pw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wen,
    input  logic          ren,
    input  logic          clear,
    output logic          wacc,
    output logic [PW-1:0] wptr,
    output logic [PW-1:0] rptr,
    output logic          empty,
    output logic          full,
    output logic          almost_empty,
    output logic          almost_full,
    output logic [CW-1:0] used_slots,
    output logic [CW-1:0] free_slots,
    output logic [CW-1:0] max_used,
    output logic          underflow,
    output logic          overflow
);

    localparam logic [PW-1:0] PtrLast   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CountMax  = CW'(DEPTH);
    localparam logic [CW-1:0] AfullLvl  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AemptyLvl = CW'(AEMPTY_THRESH);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] max_q, max_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          racc;
    fifo_flags_t   flags;

    always_comb begin
        flags              = '0;
        flags.empty        = (count_q == '0);
        flags.full         = (count_q == CountMax);
        flags.almost_full  = (count_q >= AfullLvl);
        flags.almost_empty = (count_q <= AemptyLvl);
    end

    // Reset and clear both suppress the memory write as well as the state update.
    assign wacc = rst_n && !clear && wen && !flags.full;
    assign racc = rst_n && !clear && ren && !flags.empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q + CW'(wacc) - CW'(racc);
        max_d   = (count_d > max_q) ? count_d : max_q;
        ovf_d   = wen && flags.full;
        unf_d   = ren && flags.empty;

        if (wacc) begin
            wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PW'(1);
        end
        if (racc) begin
            rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PW'(1);
        end

        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            max_d   = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            max_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            max_q   <= max_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign wptr         = wptr_q;
    assign rptr         = rptr_q;
    assign empty        = flags.empty;
    assign full         = flags.full;
    assign almost_empty = flags.almost_empty;
    assign almost_full  = flags.almost_full;
    assign used_slots   = count_q;
    assign free_slots   = CountMax - count_q;
    assign max_used     = max_q;
    assign underflow    = unf_q;
    assign overflow     = ovf_q;

    if (AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("nx_fifo_ctrl_flex: AFULL_THRESH must not exceed DEPTH");
    end
    if (AEMPTY_THRESH > DEPTH) begin : g_bad_aempty
        $error("nx_fifo_ctrl_flex: AEMPTY_THRESH must not exceed DEPTH");
    end

    if (UNDERFLOW_ASSERT) begin : g_unf_assert
        assert property (@(posedge clk) disable iff (!rst_n) !(ren && flags.empty && !clear))
            else $error("nx_fifo_ctrl_flex: read while empty");
    end
    if (OVERFLOW_ASSERT) begin : g_ovf_assert
        assert property (@(posedge clk) disable iff (!rst_n) !(wen && flags.full && !clear))
            else $error("nx_fifo_ctrl_flex: write while full");
    end

endmodule

// File: rtl/nx_fifo_flex.sv
// Parametrised first-word-fall-through FIFO: storage array and head read mux;
// all control state lives in nx_fifo_ctrl_flex.
module nx_fifo_flex
    import nx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH            = 4,
    parameter int unsigned WIDTH            = 65,
    parameter int unsigned AFULL_THRESH     = DEPTH - 1,
    parameter int unsigned AEMPTY_THRESH    = 1,
    parameter bit          DATA_RESET       = 1'b1,
    parameter bit          UNDERFLOW_ASSERT = 1'b1,
    parameter bit          OVERFLOW_ASSERT  = 1'b1,
    localparam int unsigned CW              = fifo_cw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic             ren,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [CW-1:0]    used_slots,
    output logic [CW-1:0]    free_slots,
    output logic [CW-1:0]    max_used,
    output logic             underflow,
    output logic             overflow
);

    localparam int unsigned PW = fifo_pw(DEPTH);

    logic             wacc;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [WIDTH-1:0] mem_q [DEPTH];

    nx_fifo_ctrl_flex #(
        .DEPTH            (DEPTH),
        .AFULL_THRESH     (AFULL_THRESH),
        .AEMPTY_THRESH    (AEMPTY_THRESH),
        .UNDERFLOW_ASSERT (UNDERFLOW_ASSERT),
        .OVERFLOW_ASSERT  (OVERFLOW_ASSERT)
    ) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .wen          (wen),
        .ren          (ren),
        .clear        (clear),
        .wacc         (wacc),
        .wptr         (wptr),
        .rptr         (rptr),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .used_slots   (used_slots),
        .free_slots   (free_slots),
        .max_used     (max_used),
        .underflow    (underflow),
        .overflow     (overflow)
    );

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wacc) begin
            mem_q[wptr] <= wdata;
        end
    end

    assign rdata = (DATA_RESET && empty) ? '0 : mem_q[rptr];

    if (DEPTH < 1) begin : g_bad_depth
        $error("nx_fifo_flex: DEPTH must be at least 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("nx_fifo_flex: WIDTH must be at least 1");
    end

endmodule

// File: tb/tb_nx_fifo_flex.sv
// Self-checking bench for nx_fifo_flex (DEPTH=5, WIDTH=8): hand-built vector table
// plus a queue scoreboard checked every cycle.
module tb_nx_fifo_flex;

    localparam int DEPTH = 5;

    logic       clk;
    logic       rst_n;
    logic       wen;
    logic       ren;
    logic       clear;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [2:0] used_slots;
    logic [2:0] free_slots;
    logic [2:0] max_used;
    logic       underflow;
    logic       overflow;

    nx_fifo_flex #(
        .DEPTH            (5),
        .WIDTH            (8),
        .AFULL_THRESH     (4),
        .AEMPTY_THRESH    (1),
        .DATA_RESET       (1'b1),
        .UNDERFLOW_ASSERT (1'b0),
        .OVERFLOW_ASSERT  (1'b0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wen          (wen),
        .ren          (ren),
        .clear        (clear),
        .wdata        (wdata),
        .rdata        (rdata),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .used_slots   (used_slots),
        .free_slots   (free_slots),
        .max_used     (max_used),
        .underflow    (underflow),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       r;
        logic       c;
        logic       w;
        logic       rd;
        logic [7:0] wd;
        logic [2:0] used;
        logic [7:0] rdv;
        logic [2:0] mx;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         m_max;
    logic       m_ovf;
    logic       m_unf;
    int         n_chk;
    int         n_err;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void add(input logic r, input logic c, input logic w, input logic rd,
                                input logic [7:0] wd, input logic [2:0] used,
                                input logic [7:0] rdv, input logic [2:0] mx,
                                input logic ovf, input logic unf);
        vec_t v;
        v.r = r; v.c = c; v.w = w; v.rd = rd; v.wd = wd;
        v.used = used; v.rdv = rdv; v.mx = mx; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endfunction

    task automatic check_model();
        int n;
        n = sb.size();
        chk("used", used_slots, n);
        chk("free", free_slots, DEPTH - n);
        chk("empty", empty, n == 0);
        chk("full", full, n == DEPTH);
        chk("afull", almost_full, n >= 4);
        chk("aempty", almost_empty, n <= 1);
        chk("max_used", max_used, m_max);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
        chk("rdata", rdata, (n != 0) ? sb[0] : 8'h00);
    endtask

    // Drive one cycle, step the scoreboard at the edge, compare 1 ns later.
    task automatic cycle(input logic r, input logic c, input logic w, input logic rd,
                         input logic [7:0] wd);
        int n;
        rst_n = r; clear = c; wen = w; ren = rd; wdata = wd;
        n = sb.size();
        if (r && !c && rd && n > 0) chk("pop_data", rdata, sb[0]);
        @(posedge clk);
        if (!r || c) begin
            sb.delete();
            m_max = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_ovf = w && (n == DEPTH);
            m_unf = rd && (n == 0);
            if (rd && n > 0) void'(sb.pop_front());
            if (w && n < DEPTH) sb.push_back(wd);
            if (sb.size() > m_max) m_max = sb.size();
        end
        #1;
        check_model();
    endtask

    initial begin
        n_chk = 0; n_err = 0; m_max = 0; m_ovf = 1'b0; m_unf = 1'b0;
        rst_n = 1'b0; clear = 1'b0; wen = 1'b0; ren = 1'b0; wdata = 8'h00;

        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
        chk("rst_used", used_slots, 0);
        chk("rst_free", free_slots, 5);
        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_max", max_used, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        chk("rst_rdata", rdata, 8'h00);

        //    r     c     w     rd    wd     used  rdata  max   ovf   unf
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 3'd1, 8'h11, 3'd1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 3'd2, 8'h11, 3'd2, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h13, 3'd3, 8'h11, 3'd3, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h14, 3'd4, 8'h11, 3'd4, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h15, 3'd5, 8'h11, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd4, 8'h12, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd3, 8'h13, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd2, 8'h14, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd1, 8'h15, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h00, 3'd5, 1'b0, 1'b0);
        // Refill, then write+read while full: head pops, write dropped.
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h21, 3'd1, 8'h21, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 3'd2, 8'h21, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h23, 3'd3, 8'h21, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h24, 3'd4, 8'h21, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h25, 3'd5, 8'h21, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 8'h26, 3'd4, 8'h22, 3'd5, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd4, 8'h22, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd3, 8'h23, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd2, 8'h24, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd1, 8'h25, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h00, 3'd5, 1'b0, 1'b0);
        // Read+write on empty: write lands, underflow pulses once.
        add(1'b1, 1'b0, 1'b1, 1'b1, 8'h31, 3'd1, 8'h31, 3'd5, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 8'h31, 3'd5, 1'b0, 1'b0);
        // Fill to 3, drain to 1, clear with wen high.
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h32, 3'd2, 8'h31, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 3'd3, 8'h31, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd2, 8'h32, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd1, 8'h33, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h44, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
        // Two entries, then a one-cycle reset with wen/ren high, then a write.
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h51, 3'd1, 8'h51, 3'd1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h52, 3'd2, 8'h51, 3'd2, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 8'h53, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h54, 3'd1, 8'h54, 3'd1, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].r, vecs[i].c, vecs[i].w, vecs[i].rd, vecs[i].wd);
            chk($sformatf("vec%0d_used", i), used_slots, vecs[i].used);
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdv);
            chk($sformatf("vec%0d_max", i), max_used, vecs[i].mx);
            chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
            chk($sformatf("vec%0d_unf", i), underflow, vecs[i].unf);
        end

        // Twelve write/read pairs with one entry in flight wrap both pointers twice.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'(8'h60 + i));
            chk("wrap_used", used_slots, 1);
            chk("wrap_data", rdata, 8'(8'h60 + i));
        end

        for (int i = 0; i < 120; i++) begin
            cycle(1'b1, ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
